// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one memory bus between an instruction-fetch port and a
//               load/store port; optional round-robin via MEM_ARB_FAIR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    if_en,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_stall,
    input  logic                    data_en,
    input  logic [DATA_WIDTH/8-1:0] data_wen,
    input  logic [ADDR_WIDTH-1:0]   data_addr,
    input  logic [DATA_WIDTH-1:0]   data_wdata,
    output logic [DATA_WIDTH-1:0]   data_rdata,
    output logic                    data_stall,
    output logic                    bus_en,
    output logic [DATA_WIDTH/8-1:0] bus_wen,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    input  logic [DATA_WIDTH-1:0]   bus_rdata,
    input  logic                    bus_ready
);

    localparam int c_WEN_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BUSY_IF   = 2'd1,
        ST_BUSY_DATA = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_discard;
    logic                    r_if_done;
    logic                    r_data_done;
    logic [DATA_WIDTH-1:0]   r_if_rdata;
    logic [DATA_WIDTH-1:0]   r_data_rdata;
    logic [c_WEN_W-1:0]      r_bus_wen;
    logic [ADDR_WIDTH-1:0]   r_bus_addr;
    logic [DATA_WIDTH-1:0]   r_bus_wdata;

    logic w_grant_data;
    logic w_grant_if;
    logic w_prefer_data;
    logic w_disc;
    logic w_if_cpl;
    logic w_data_cpl;
    logic w_if_pend;
    logic w_data_pend;
    logic w_if_stall;
    logic w_data_stall;
    logic w_advance;

    // A flush in the completion cycle itself also discards that result.
    assign w_disc      = r_discard | flush;
    assign w_if_cpl    = (r_state == ST_BUSY_IF)   & bus_ready & ~w_disc & if_en;
    assign w_data_cpl  = (r_state == ST_BUSY_DATA) & bus_ready & ~w_disc & data_en;
    assign w_if_pend   = if_en   & ~r_if_done;
    assign w_data_pend = data_en & ~r_data_done;

    assign w_if_stall   = ~flush & if_en   & ~r_if_done   & ~w_if_cpl;
    assign w_data_stall = ~flush & data_en & ~r_data_done & ~w_data_cpl;
    assign w_advance    = ~w_if_stall & ~w_data_stall;

`ifdef MEM_ARB_FAIR_EN
    logic r_last_data;

    assign w_prefer_data = ~r_last_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_data <= 1'b0;
        end else if (w_grant_data) begin
            r_last_data <= 1'b1;
        end else if (w_grant_if) begin
            r_last_data <= 1'b0;
        end
    end
`else
    assign w_prefer_data = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grants are only made from IDLE, so each access costs at least two cycles.
    always_comb begin
        w_state_next = r_state;
        w_grant_data = 1'b0;
        w_grant_if   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!flush) begin
                    if (w_data_pend && (!w_if_pend || w_prefer_data)) begin
                        w_grant_data = 1'b1;
                        w_state_next = ST_BUSY_DATA;
                    end else if (w_if_pend) begin
                        w_grant_if   = 1'b1;
                        w_state_next = ST_BUSY_IF;
                    end
                end
            end
            ST_BUSY_IF, ST_BUSY_DATA: begin
                if (bus_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bus_wen   <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else if (w_grant_data) begin
            r_bus_wen   <= data_wen;
            r_bus_addr  <= data_addr;
            r_bus_wdata <= data_wdata;
        end else if (w_grant_if) begin
            r_bus_wen   <= '0;
            r_bus_addr  <= if_addr;
        end
    end

    // A flushed access still runs to completion but its result is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_discard <= 1'b0;
        end else if (r_state == ST_IDLE || bus_ready) begin
            r_discard <= 1'b0;
        end else if (flush) begin
            r_discard <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_done    <= 1'b0;
            r_data_done  <= 1'b0;
            r_if_rdata   <= '0;
            r_data_rdata <= '0;
        end else begin
            if (w_advance) begin
                r_if_done   <= 1'b0;
                r_data_done <= 1'b0;
            end else begin
                if (w_if_cpl) begin
                    r_if_done <= 1'b1;
                end
                if (w_data_cpl) begin
                    r_data_done <= 1'b1;
                end
            end
            if (w_if_cpl) begin
                r_if_rdata <= bus_rdata;
            end
            if (w_data_cpl && (r_bus_wen == '0)) begin
                r_data_rdata <= bus_rdata;
            end
        end
    end

    assign bus_en     = (r_state != ST_IDLE);
    assign bus_wen    = r_bus_wen;
    assign bus_addr   = r_bus_addr;
    assign bus_wdata  = r_bus_wdata;
    assign if_rdata   = w_if_cpl   ? bus_rdata : r_if_rdata;
    assign data_rdata = w_data_cpl ? bus_rdata : r_data_rdata;
    assign if_stall   = w_if_stall;
    assign data_stall = w_data_stall;

endmodule
`default_nettype wire
